// File: rtl/fpu_pkg.sv
// Purpose: shared constants and FSM state type for the FPU mantissa normalizer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fpu_pkg;

    // Default datapath widths; normalized mantissa has bit MANT_W-1 set.
    localparam int MANT_W_DFLT = 15;
    localparam int EXP_W_DFLT  = 8;

    // All-ones biased exponent marks overflow / infinity.
    localparam logic [EXP_W_DFLT-1:0] EXP_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } norm_state_t;

endpackage

// File: rtl/fpu_mant_normalize_if.sv
// Purpose: upstream (adder) and downstream (rounder) handshake bundle of the normalizer.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both sides; slave = normalizer view, master = driver view.
//
// Signals:
//   in_valid/in_ready   upstream handshake
//   in_sum/in_carry/in_exp/in_sign/in_sticky   adder result
//   out_valid/out_ready downstream handshake
//   out_mant/out_exp/out_sign/out_sticky/out_zero/out_underflow/out_overflow   result
interface fpu_mant_normalize_if
    import fpu_pkg::*;
#(
    parameter int MANT_W = MANT_W_DFLT,
    parameter int EXP_W  = EXP_W_DFLT
);
    logic              in_valid;
    logic              in_ready;
    logic [MANT_W-1:0] in_sum;
    logic              in_carry;
    logic [EXP_W-1:0]  in_exp;
    logic              in_sign;
    logic              in_sticky;

    logic              out_valid;
    logic              out_ready;
    logic [MANT_W-1:0] out_mant;
    logic [EXP_W-1:0]  out_exp;
    logic              out_sign;
    logic              out_sticky;
    logic              out_zero;
    logic              out_underflow;
    logic              out_overflow;

    modport slave (
        input  in_valid, in_sum, in_carry, in_exp, in_sign, in_sticky, out_ready,
        output in_ready, out_valid, out_mant, out_exp, out_sign, out_sticky,
               out_zero, out_underflow, out_overflow
    );

    modport master (
        output in_valid, in_sum, in_carry, in_exp, in_sign, in_sticky, out_ready,
        input  in_ready, out_valid, out_mant, out_exp, out_sign, out_sticky,
               out_zero, out_underflow, out_overflow
    );

endinterface

// File: rtl/fpu_mant_normalize.sv
// Purpose: iterative post-add normalizer (1-bit right shift on carry, 1-bit/cycle left shifts).
// Latency: result valid 2 cycles after the accept cycle, plus one cycle per left shift.
// Backpressure: single operand in flight; in_ready only in IDLE, result held until out_ready.
//
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   bus       fpu_mant_normalize_if.slave (upstream + downstream handshakes and data)
//   busy      high whenever the FSM is not IDLE
module fpu_mant_normalize
    import fpu_pkg::*;
#(
    parameter int MANT_W = MANT_W_DFLT,
    parameter int EXP_W  = EXP_W_DFLT
)(
    input  logic                 clk,
    input  logic                 rst,
    fpu_mant_normalize_if.slave  bus,
    output logic                 busy
);

    localparam logic [EXP_W-1:0] EXP_ONES = '1;

    norm_state_t       state_q, state_d;
    logic [MANT_W-1:0] mant_q, mant_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic              carry_q, carry_d;
    logic              sign_q, sign_d;
    logic              sticky_q, sticky_d;
    logic              zero_q, zero_d;
    logic              unf_q, unf_d;
    logic              ovf_q, ovf_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mant_q   <= '0;
            exp_q    <= '0;
            carry_q  <= 1'b0;
            sign_q   <= 1'b0;
            sticky_q <= 1'b0;
            zero_q   <= 1'b0;
            unf_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mant_q   <= mant_d;
            exp_q    <= exp_d;
            carry_q  <= carry_d;
            sign_q   <= sign_d;
            sticky_q <= sticky_d;
            zero_q   <= zero_d;
            unf_q    <= unf_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mant_d   = mant_q;
        exp_d    = exp_q;
        carry_d  = carry_q;
        sign_d   = sign_q;
        sticky_d = sticky_q;
        zero_d   = zero_q;
        unf_d    = unf_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && bus.in_ready) begin
                    mant_d   = bus.in_sum;
                    exp_d    = bus.in_exp;
                    carry_d  = bus.in_carry;
                    sign_d   = bus.in_sign;
                    sticky_d = bus.in_sticky;
                    zero_d   = 1'b0;
                    unf_d    = 1'b0;
                    ovf_d    = 1'b0;
                    state_d  = NORM;
                end
            end

            NORM: begin
                if (carry_q) begin
                    // Mantissa overflowed: shift right once, the dropped bit
                    // folds into sticky. The >= compare also covers an input
                    // exponent already at all-ones so the increment cannot wrap.
                    carry_d  = 1'b0;
                    sticky_d = sticky_q | mant_q[0];
                    state_d  = DONE;
                    if (exp_q >= EXP_ONES - 1'b1) begin
                        ovf_d  = 1'b1;
                        exp_d  = EXP_ONES;
                        mant_d = '0;
                    end else begin
                        exp_d  = exp_q + 1'b1;
                        mant_d = {1'b1, mant_q[MANT_W-1:1]};
                    end
                end else if (mant_q == '0) begin
                    zero_d  = 1'b1;
                    exp_d   = '0;
                    state_d = DONE;
                end else if (mant_q[MANT_W-1]) begin
                    state_d = DONE;
                end else if (exp_q == '0) begin
                    // Denormal: exponent exhausted before the leading one arrived.
                    unf_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    mant_d = {mant_q[MANT_W-2:0], 1'b0};
                    exp_d  = exp_q - 1'b1;
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready      = (state_q == IDLE) && !rst;
    assign bus.out_valid     = (state_q == DONE);
    assign bus.out_mant      = mant_q;
    assign bus.out_exp       = exp_q;
    assign bus.out_sign      = sign_q;
    assign bus.out_sticky    = sticky_q;
    assign bus.out_zero      = zero_q;
    assign bus.out_underflow = unf_q;
    assign bus.out_overflow  = ovf_q;
    assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_fpu_mant_normalize.sv
// Purpose: self-checking bench for fpu_mant_normalize (directed cases + randomized vs. model).
// Latency: cycle 0 is the cycle in_valid is accepted; result expected in cycle 2+shifts.
// Backpressure: exercises held out_ready, ignored in_valid while busy, and mid-shift reset.
module tb_fpu_mant_normalize;
    import fpu_pkg::*;

    logic clk;
    logic rst;
    logic busy;
    int   checks;
    int   failures;

    fpu_mant_normalize_if #(.MANT_W(15), .EXP_W(8)) bus ();

    fpu_mant_normalize #(.MANT_W(15), .EXP_W(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] mant;
        logic [7:0]  exp;
        bit          sticky;
        bit          zero;
        bit          unf;
        bit          ovf;
        int          lat;
    } exp_t;

    // Reference: applies the normalization rules with plain integer arithmetic.
    function automatic exp_t ref_model(input int sum, input bit carry, input int exp, input bit sticky);
        exp_t r;
        int   m;
        int   e;
        int   k;
        r.sticky = sticky;
        r.zero = 0;
        r.unf = 0;
        r.ovf = 0;
        m = sum;
        e = exp;
        if (carry) begin
            r.sticky = sticky | (m % 2 == 1);
            if (e + 1 >= 255) begin
                r.ovf  = 1;
                r.exp  = 8'd255;
                r.mant = '0;
            end else begin
                r.exp  = 8'(e + 1);
                r.mant = 15'(16384 + m / 2);
            end
            r.lat = 2;
        end else if (m == 0) begin
            r.zero = 1;
            r.exp  = '0;
            r.mant = '0;
            r.lat  = 2;
        end else begin
            k = 0;
            while (m < 16384 && e > 0) begin
                m = m * 2;
                e = e - 1;
                k = k + 1;
            end
            r.unf  = (m < 16384);
            r.mant = 15'(m);
            r.exp  = 8'(e);
            r.lat  = 2 + k;
        end
        return r;
    endfunction

    // Presents one operand and returns in the first cycle out_valid is seen.
    // lat = cycle index of that observation (accept cycle = 0), -1 on timeout.
    task automatic drive_op(input logic [14:0] sum, input bit carry, input logic [7:0] exp,
                            input bit sign, input bit sticky, input bit hold, output int lat);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        bus.in_sum    = sum;
        bus.in_carry  = carry;
        bus.in_exp    = exp;
        bus.in_sign   = sign;
        bus.in_sticky = sticky;
        bus.out_ready = !hold;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (bus.out_valid !== 1'b1) lat = -1;
    endtask

    task automatic finish_op();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready);
        end
        checks++;
        if ({busy, bus.out_valid, bus.out_mant, bus.out_exp, bus.out_sign, bus.out_sticky,
             bus.out_zero, bus.out_underflow, bus.out_overflow} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b v=%b m=%h e=%h s=%b st=%b z=%b u=%b o=%b want all 0",
                     busy, bus.out_valid, bus.out_mant, bus.out_exp, bus.out_sign, bus.out_sticky,
                     bus.out_zero, bus.out_underflow, bus.out_overflow);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL idle_in_ready got %b want 1", bus.in_ready);
        end
    endtask

    // Directed cases with hand-derived expectations.
    task automatic test_directed();
        logic [14:0] t_sum  [6] = '{15'h4000, 15'h0001, 15'h0003, 15'h1234, 15'h0000, 15'h0010};
        bit          t_cy   [6] = '{0, 0, 1, 1, 0, 0};
        logic [7:0]  t_exp  [6] = '{8'd100, 8'd100, 8'd100, 8'hFE, 8'd57, 8'd3};
        logic [14:0] w_mant [6] = '{15'h4000, 15'h4000, 15'h4001, 15'h0000, 15'h0000, 15'h0080};
        logic [7:0]  w_exp  [6] = '{8'd100, 8'd86, 8'd101, EXP_MAX, 8'd0, 8'd0};
        bit          w_st   [6] = '{0, 0, 1, 0, 0, 0};
        bit          w_z    [6] = '{0, 0, 0, 0, 1, 0};
        bit          w_u    [6] = '{0, 0, 0, 0, 0, 1};
        bit          w_o    [6] = '{0, 0, 0, 1, 0, 0};
        int          w_lat  [6] = '{2, 16, 2, 2, 2, 5};
        int          lat;
        for (int i = 0; i < 6; i++) begin
            drive_op(t_sum[i], t_cy[i], t_exp[i], i[0], 1'b0, 1'b0, lat);
            checks++;
            if (lat !== w_lat[i]) begin
                failures++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, w_lat[i]);
            end
            checks++;
            if (bus.out_mant !== w_mant[i] || bus.out_exp !== w_exp[i]) begin
                failures++;
                $display("FAIL dir%0d_mant_exp got %h/%0d want %h/%0d", i, bus.out_mant, bus.out_exp, w_mant[i], w_exp[i]);
            end
            checks++;
            if ({bus.out_sign, bus.out_sticky, bus.out_zero, bus.out_underflow, bus.out_overflow}
                !== {i[0], w_st[i], w_z[i], w_u[i], w_o[i]}) begin
                failures++;
                $display("FAIL dir%0d_flags got s/st/z/u/o=%b%b%b%b%b want %b%b%b%b%b", i,
                         bus.out_sign, bus.out_sticky, bus.out_zero, bus.out_underflow, bus.out_overflow,
                         i[0], w_st[i], w_z[i], w_u[i], w_o[i]);
            end
            finish_op();
        end
    endtask

    task automatic test_random();
        logic [14:0] sum;
        bit          cy;
        logic [7:0]  ex;
        bit          sg;
        bit          st;
        exp_t        r;
        int          lat;
        for (int i = 0; i < 60; i++) begin
            sum = 15'($urandom) >> $urandom_range(0, 15);
            cy  = ($urandom_range(0, 5) == 0);
            ex  = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 16)) : 8'($urandom);
            if ($urandom_range(0, 9) == 0) ex = 8'hFE + 8'($urandom_range(0, 1));
            sg  = 1'($urandom);
            st  = 1'($urandom);
            r   = ref_model(int'(sum), cy, int'(ex), st);
            drive_op(sum, cy, ex, sg, st, 1'b0, lat);
            checks++;
            if (lat !== r.lat || bus.out_mant !== r.mant || bus.out_exp !== r.exp || bus.out_sign !== sg
                || {bus.out_sticky, bus.out_zero, bus.out_underflow, bus.out_overflow} !== {r.sticky, r.zero, r.unf, r.ovf}) begin
                failures++;
                $display("FAIL rand%0d in=%h/%b/%0d got lat=%0d m=%h e=%0d s=%b st/z/u/o=%b%b%b%b want lat=%0d m=%h e=%0d s=%b %b%b%b%b",
                         i, sum, cy, ex, lat, bus.out_mant, bus.out_exp, bus.out_sign, bus.out_sticky,
                         bus.out_zero, bus.out_underflow, bus.out_overflow,
                         r.lat, r.mant, r.exp, sg, r.sticky, r.zero, r.unf, r.ovf);
            end
            finish_op();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        drive_op(15'h4000, 1'b0, 8'd100, 1'b1, 1'b0, 1'b1, lat);
        checks++;
        if (lat !== 2) begin
            failures++; $display("FAIL bp_latency got %0d want 2", lat);
        end
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                bus.in_sum   = 15'h0001;
                bus.in_exp   = 8'd9;
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_mant !== 15'h4000
                || bus.out_exp !== 8'd100 || bus.out_sign !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold%0d got v=%b rdy=%b m=%h e=%0d s=%b want 1 0 4000 100 1",
                         c, bus.out_valid, bus.in_ready, bus.out_mant, bus.out_exp, bus.out_sign);
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        finish_op();
        checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release got v=%b busy=%b rdy=%b want 0 0 1", bus.out_valid, busy, bus.in_ready);
        end
    endtask

    task automatic test_reset_midshift();
        int lat;
        bus.in_sum    = 15'h0001;
        bus.in_carry  = 1'b0;
        bus.in_exp    = 8'd100;
        bus.in_sign   = 1'b1;
        bus.in_sticky = 1'b1;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL rst_mid_busy_before got %b want 1", busy);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({busy, bus.out_valid, bus.out_mant, bus.out_exp, bus.out_sign, bus.out_sticky,
             bus.out_zero, bus.out_underflow, bus.out_overflow} !== '0) begin
            failures++;
            $display("FAIL rst_mid_outputs got busy=%b v=%b m=%h e=%h s=%b st=%b z=%b u=%b o=%b want all 0",
                     busy, bus.out_valid, bus.out_mant, bus.out_exp, bus.out_sign, bus.out_sticky,
                     bus.out_zero, bus.out_underflow, bus.out_overflow);
        end
        drive_op(15'h0400, 1'b0, 8'd20, 1'b0, 1'b0, 1'b0, lat);
        checks++;
        if (lat !== 6 || bus.out_mant !== 15'h4000 || bus.out_exp !== 8'd16) begin
            failures++;
            $display("FAIL rst_mid_after got lat=%0d m=%h e=%0d want 6 4000 16", lat, bus.out_mant, bus.out_exp);
        end
        finish_op();
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sum    = '0;
        bus.in_carry  = 1'b0;
        bus.in_exp    = '0;
        bus.in_sign   = 1'b0;
        bus.in_sticky = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midshift();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
